// File: rtl/lcd_pkg.sv
// Shared constants, types and address helpers for the HD44780-style bus receiver.
package lcd_pkg;
    localparam int COLS  = 16;
    localparam int ROWS  = 2;
    localparam int CELLS = COLS * ROWS;

    localparam logic [7:0] OP_CLEAR = 8'h01;
    localparam logic [7:0] OP_HOME  = 8'h02;
    localparam logic [7:0] OP_ENTRY = 8'h04;
    localparam logic [7:0] OP_DISP  = 8'h08;
    localparam logic [7:0] OP_SHIFT = 8'h10;
    localparam logic [7:0] OP_FUNC  = 8'h20;
    localparam logic [7:0] OP_CGRAM = 8'h40;
    localparam logic [7:0] OP_DDRAM = 8'h80;

    localparam logic [6:0] LINE1_BASE   = 7'h00;
    localparam logic [6:0] LINE2_BASE   = 7'h40;
    localparam logic [6:0] LINE1_END    = 7'h27;
    localparam logic [6:0] LINE2_END    = 7'h67;
    localparam logic [6:0] ONE_LINE_END = 7'h4F;

    typedef enum logic [1:0] {ST_IDLE, ST_EXEC, ST_CLEAR} state_e;

    typedef enum logic [3:0] {
        CMD_NOP, CMD_CLEAR, CMD_HOME, CMD_ENTRY, CMD_DISP,
        CMD_SHIFT, CMD_FUNC, CMD_CGRAM, CMD_DDRAM
    } cmd_e;

    typedef struct packed {
        logic       rs;
        logic       rw;
        logic       e;
        logic [7:0] data;
    } bus_s;

    // Checks run lowest to highest so the highest set bit wins.
    function automatic cmd_e decode_cmd(input logic [7:0] d);
        cmd_e c;
        c = CMD_NOP;
        if (|(d & OP_CLEAR)) c = CMD_CLEAR;
        if (|(d & OP_HOME))  c = CMD_HOME;
        if (|(d & OP_ENTRY)) c = CMD_ENTRY;
        if (|(d & OP_DISP))  c = CMD_DISP;
        if (|(d & OP_SHIFT)) c = CMD_SHIFT;
        if (|(d & OP_FUNC))  c = CMD_FUNC;
        if (|(d & OP_CGRAM)) c = CMD_CGRAM;
        if (|(d & OP_DDRAM)) c = CMD_DDRAM;
        return c;
    endfunction

    function automatic logic [6:0] step_addr(input logic [6:0] a, input logic inc, input logic two);
        logic [6:0] n;
        n = inc ? a + 7'd1 : a - 7'd1;
        if (two) begin
            if (inc && a == LINE1_END)        n = LINE2_BASE;
            else if (inc && a == LINE2_END)   n = LINE1_BASE;
            else if (!inc && a == LINE1_BASE) n = LINE2_END;
            else if (!inc && a == LINE2_BASE) n = LINE1_END;
        end else begin
            if (inc && a == ONE_LINE_END)     n = LINE1_BASE;
            else if (!inc && a == LINE1_BASE) n = ONE_LINE_END;
        end
        return n;
    endfunction

    // {hit, cell index}: only the first 16 columns of each line are stored.
    function automatic logic [5:0] map_cell(input logic [6:0] a);
        logic [5:0] r;
        r = '0;
        if (a[6:4] == LINE1_BASE[6:4])      r = {2'b10, a[3:0]};
        else if (a[6:4] == LINE2_BASE[6:4]) r = {2'b11, a[3:0]};
        return r;
    endfunction
endpackage

// File: rtl/lcd_rx_if.sv
// Pin-level HD44780-style bus between an LCD driver (master) and the receiver (slave).
interface lcd_rx_if;
    logic       lcd_rs;
    logic       lcd_rw;
    logic       lcd_e;
    logic [7:0] lcd_data;

    modport master (output lcd_rs, lcd_rw, lcd_e, lcd_data);
    modport slave  (input  lcd_rs, lcd_rw, lcd_e, lcd_data);
endinterface

// File: rtl/lcd_bus_sync.sv
// Synchronizes the asynchronous LCD bus and flags each falling edge of E.
module lcd_bus_sync import lcd_pkg::*; #(
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  bus_s       i_bus,
    output logic       o_strobe,
    output logic       o_rs,
    output logic       o_rw,
    output logic [7:0] o_data
);
    bus_s [SYNC_STAGES-1:0] r_sync;
    logic                   r_e_prev;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_sync   <= '0;
            r_e_prev <= 1'b0;
        end else begin
            r_sync   <= {r_sync[SYNC_STAGES-2:0], i_bus};
            r_e_prev <= r_sync[SYNC_STAGES-1].e;
        end
    end

    // rs/rw/data come from the same stage as the E sample that fell.
    assign o_strobe = r_e_prev & ~r_sync[SYNC_STAGES-1].e;
    assign o_rs     = r_sync[SYNC_STAGES-1].rs;
    assign o_rw     = r_sync[SYNC_STAGES-1].rw;
    assign o_data   = r_sync[SYNC_STAGES-1].data;
endmodule

// File: rtl/lcd_rx.sv
// Passive HD44780 bus snooper: decodes instructions and mirrors the 2x16 visible DDRAM.
module lcd_rx import lcd_pkg::*; #(
    parameter int         SYNC_STAGES = 2,
    parameter logic [7:0] BLANK_CHAR  = 8'h20
) (
    input  logic       clk,
    input  logic       rst,
    lcd_rx_if.slave    bus,
    input  logic [4:0] rd_index,
    output logic [7:0] rd_char,
    output logic       disp_on,
    output logic [6:0] ddram_addr,
    output logic       busy,
    output logic       cmd_pulse,
    output logic       data_pulse,
    output logic       overrun
);
    bus_s                  w_bus_in;
    logic                  w_strobe, w_rs, w_rw, w_accept, w_drop;
    logic [7:0]            w_data;
    logic [5:0]            w_cell;
    state_e                r_state, w_state_nx;
    logic                  r_rs;
    logic [7:0]            r_op;
    logic [CELLS-1:0][7:0] r_cells;
    logic [4:0]            r_clr_idx;
    logic [6:0]            r_addr;
    logic                  r_inc, r_two_line, r_cgram, r_disp_on;
    logic                  r_cmd_pulse, r_data_pulse, r_overrun;
    logic [7:0]            r_rd_char;

    assign w_bus_in = {bus.lcd_rs, bus.lcd_rw, bus.lcd_e, bus.lcd_data};

    lcd_bus_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
        .clk(clk), .rst(rst), .i_bus(w_bus_in),
        .o_strobe(w_strobe), .o_rs(w_rs), .o_rw(w_rw), .o_data(w_data)
    );

    // Reads (rw=1) are invisible: no pulse, no overrun.
    assign w_accept = w_strobe & ~w_rw & (r_state == ST_IDLE);
    assign w_drop   = w_strobe & ~w_rw & (r_state != ST_IDLE);
    assign w_cell   = map_cell(r_addr);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_state <= ST_IDLE;
        else      r_state <= w_state_nx;
    end

    always_comb begin
        w_state_nx = r_state;
        case (r_state)
            ST_IDLE:  if (w_accept) w_state_nx = ST_EXEC;
            ST_EXEC:  w_state_nx = (!r_rs && decode_cmd(r_op) == CMD_CLEAR) ? ST_CLEAR : ST_IDLE;
            ST_CLEAR: if (r_clr_idx == 5'(CELLS - 1)) w_state_nx = ST_IDLE;
            default:  w_state_nx = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cells      <= {CELLS{BLANK_CHAR}};
            r_rd_char    <= BLANK_CHAR;
            r_rs         <= 1'b0;
            r_op         <= '0;
            r_clr_idx    <= '0;
            r_addr       <= '0;
            r_inc        <= 1'b1;
            r_two_line   <= 1'b0;
            r_cgram      <= 1'b0;
            r_disp_on    <= 1'b0;
            r_cmd_pulse  <= 1'b0;
            r_data_pulse <= 1'b0;
            r_overrun    <= 1'b0;
        end else begin
            r_cmd_pulse  <= 1'b0;
            r_data_pulse <= 1'b0;
            r_rd_char    <= r_cells[rd_index];
            if (w_drop) r_overrun <= 1'b1;
            if (w_accept) begin
                r_rs <= w_rs;
                r_op <= w_data;
            end
            case (r_state)
                ST_EXEC: begin
                    if (r_rs) begin
                        r_data_pulse <= 1'b1;
                        if (!r_cgram && w_cell[5]) r_cells[w_cell[4:0]] <= r_op;
                        r_addr <= step_addr(r_addr, r_inc, r_two_line);
                    end else begin
                        r_cmd_pulse <= 1'b1;
                        case (decode_cmd(r_op))
                            CMD_CLEAR: r_clr_idx  <= '0;
                            CMD_HOME:  r_addr     <= LINE1_BASE;
                            CMD_ENTRY: r_inc      <= r_op[1];
                            CMD_DISP:  r_disp_on  <= r_op[2];
                            CMD_SHIFT: if (!r_op[3]) r_addr <= r_op[2] ? r_addr + 7'd1 : r_addr - 7'd1;
                            CMD_FUNC:  r_two_line <= r_op[3];
                            CMD_CGRAM: r_cgram    <= 1'b1;
                            CMD_DDRAM: begin
                                r_cgram <= 1'b0;
                                r_addr  <= r_op[6:0];
                            end
                            default: ;
                        endcase
                    end
                end
                ST_CLEAR: begin
                    r_cells[r_clr_idx] <= BLANK_CHAR;
                    r_clr_idx          <= r_clr_idx + 5'd1;
                    if (r_clr_idx == 5'(CELLS - 1)) begin
                        r_addr <= LINE1_BASE;
                        r_inc  <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign rd_char    = r_rd_char;
    assign disp_on    = r_disp_on;
    assign ddram_addr = r_addr;
    assign busy       = (r_state == ST_CLEAR);
    assign cmd_pulse  = r_cmd_pulse;
    assign data_pulse = r_data_pulse;
    assign overrun    = r_overrun;
endmodule

// File: tb/tb_lcd_rx.sv
// Randomized bench for lcd_rx against a behavioural display model.
module tb_lcd_rx;
    localparam int SS = 2;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [4:0] rd_index = 5'd0;
    logic [7:0] rd_char;
    logic [6:0] ddram_addr;
    logic       disp_on, busy, cmd_pulse, data_pulse, overrun;

    lcd_rx_if bus();

    lcd_rx #(.SYNC_STAGES(SS), .BLANK_CHAR(8'h20)) dut (
        .clk(clk), .rst(rst), .bus(bus), .rd_index(rd_index), .rd_char(rd_char),
        .disp_on(disp_on), .ddram_addr(ddram_addr), .busy(busy),
        .cmd_pulse(cmd_pulse), .data_pulse(data_pulse), .overrun(overrun)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int errs  = 0;
    bit chk_en = 0, chk_prev = 0;

    // Model state: visible cells plus instruction-level registers.
    logic [7:0] m_cell [32];
    int m_addr;
    bit m_inc, m_two, m_disp, m_cg, m_ovr;

    task automatic chk(input string nm, input int act, input int exp);
        tests++;
        if (act != exp) begin
            errs++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    task automatic m_reset();
        foreach (m_cell[i]) m_cell[i] = 8'h20;
        m_addr = 0; m_inc = 1; m_two = 0; m_disp = 0; m_cg = 0; m_ovr = 0;
    endtask

    function automatic int m_cell_of(input int a);
        if (a < 16) return a;
        if (a >= 64 && a < 80) return a - 48;
        return -1;
    endfunction

    // Visible addresses form a ring of 80 positions; anything else just counts mod 128.
    function automatic int m_step(input int a, input bit up, input bit two);
        int p;
        if (two && (a <= 39 || (a >= 64 && a <= 103))) begin
            p = (a < 64) ? a : a - 24;
            p = (p + (up ? 1 : 79)) % 80;
            return (p < 40) ? p : p + 24;
        end
        if (!two && a <= 79) return (a + (up ? 1 : 79)) % 80;
        return (a + (up ? 1 : 127)) % 128;
    endfunction

    task automatic m_apply(input bit rs, input logic [7:0] d);
        int c;
        if (rs) begin
            c = m_cell_of(m_addr);
            if (!m_cg && c >= 0) m_cell[c] = d;
            m_addr = m_step(m_addr, m_inc, m_two);
        end
        else if (d >= 128) begin m_cg = 0; m_addr = d - 128; end
        else if (d >= 64) m_cg = 1;
        else if (d >= 32) m_two = d[3];
        else if (d >= 16) begin if (!d[3]) m_addr = (m_addr + (d[2] ? 1 : 127)) % 128; end
        else if (d >= 8) m_disp = d[2];
        else if (d >= 4) m_inc = d[1];
        else if (d >= 2) m_addr = 0;
        else if (d == 1) begin
            foreach (m_cell[i]) m_cell[i] = 8'h20;
            m_addr = 0; m_inc = 1;
        end
    endtask

    // Full bus write: checks latency, pulse kind and (for clear) busy length.
    task automatic bus_xfer(input bit rs, input bit rw, input logic [7:0] d);
        int lat, n;
        @(posedge clk); #1;
        chk_en = 0;
        bus.lcd_rs = rs; bus.lcd_rw = rw; bus.lcd_data = d; bus.lcd_e = 1'b1;
        repeat (3) @(posedge clk);
        #1 bus.lcd_e = 1'b0;
        lat = 0;
        for (int c = 1; c <= 12 && lat == 0; c++) begin
            @(posedge clk); #3;
            if (cmd_pulse || data_pulse) lat = c;
        end
        if (rw) begin
            chk("rw_ignored", lat, 0);
        end else begin
            chk("latency", lat, SS + 2);
            chk("pulse_kind", {cmd_pulse, data_pulse}, rs ? 1 : 2);
            if (!rs && d == 8'h01) begin
                n = 0;
                while (busy && n < 100) begin n++; @(posedge clk); #3; end
                chk("busy_cycles", n, 32);
            end
            m_apply(rs, d);
        end
        chk_en = 1;
    endtask

    task automatic strobe_raw(input bit rs, input logic [7:0] d);
        @(posedge clk); #1;
        bus.lcd_rs = rs; bus.lcd_rw = 1'b0; bus.lcd_data = d; bus.lcd_e = 1'b1;
        repeat (2) @(posedge clk);
        #1 bus.lcd_e = 1'b0;
        repeat (4) @(posedge clk);
    endtask

    // Every-cycle comparison; rd_index sweeps all cells.
    initial begin
        forever begin
            @(negedge clk);
            if (chk_en && chk_prev) begin
                chk("rd_char", rd_char, m_cell[rd_index]);
                chk("ddram_addr", ddram_addr, m_addr);
                chk("disp_on", disp_on, m_disp);
                chk("overrun", overrun, m_ovr);
                chk("busy_idle", busy, 0);
                chk("pulses_idle", {cmd_pulse, data_pulse}, 0);
            end
            chk_prev = chk_en;
            rd_index = rd_index + 5'd1;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        string      clk_s;
        logic [7:0] exp_clk [8];
        logic [7:0] b [17];
        logic [7:0] d;
        int         r, n;

        bus.lcd_rs = 0; bus.lcd_rw = 0; bus.lcd_e = 0; bus.lcd_data = 0;
        m_reset();
        #12;
        chk("rst_rd_char", rd_char, 8'h20);
        chk("rst_disp_on", disp_on, 0);
        chk("rst_addr", ddram_addr, 0);
        chk("rst_busy", busy, 0);
        chk("rst_pulses", {cmd_pulse, data_pulse}, 0);
        chk("rst_overrun", overrun, 0);
        @(posedge clk); #1 rst = 1'b1;
        chk_en = 1;

        bus_xfer(0, 0, 8'h38);
        bus_xfer(0, 0, 8'h0C);
        bus_xfer(0, 0, 8'h06);
        bus_xfer(0, 0, 8'h01);
        chk("init_two_line", m_two, 1);
        chk("init_disp_on", disp_on, 1);
        repeat (40) @(posedge clk);

        clk_s = "12:34:56";
        exp_clk = '{8'h31, 8'h32, 8'h3A, 8'h33, 8'h34, 8'h3A, 8'h35, 8'h36};
        bus_xfer(0, 0, 8'h80);
        for (int i = 0; i < 8; i++) bus_xfer(1, 0, clk_s[i]);
        for (int i = 0; i < 8; i++) chk("clock_cell", m_cell[i], exp_clk[i]);
        chk("clock_addr", ddram_addr, 8'h08);
        repeat (40) @(posedge clk);

        bus_xfer(0, 0, 8'hC0);
        for (int i = 0; i < 17; i++) begin
            b[i] = 8'($urandom);
            bus_xfer(1, 0, b[i]);
        end
        for (int i = 0; i < 16; i++) chk("line2_cell", m_cell[16 + i], b[i]);
        chk("line2_addr", ddram_addr, 8'h51);
        repeat (40) @(posedge clk);

        bus_xfer(0, 0, 8'hA7);
        bus_xfer(1, 0, 8'h41);
        chk("wrap_27_40", ddram_addr, 8'h40);
        repeat (40) @(posedge clk);

        bus_xfer(0, 0, 8'h04);
        bus_xfer(0, 0, 8'h8F);
        bus_xfer(1, 0, 8'h58);
        chk("dec_cell15", m_cell[15], 8'h58);
        chk("dec_addr", ddram_addr, 8'h0E);
        bus_xfer(1, 1, 8'h77);
        chk("rw_addr", ddram_addr, 8'h0E);
        repeat (40) @(posedge clk);

        // Strobe during CLEAR must be dropped and flagged.
        chk_en = 0;
        strobe_raw(0, 8'h01);
        strobe_raw(1, 8'h55);
        n = 0;
        while (busy && n < 100) begin n++; @(posedge clk); #3; end
        chk("ovr_clear_done", busy, 0);
        m_apply(0, 8'h01);
        m_ovr = 1;
        chk("ovr_flag", overrun, 1);
        chk_en = 1;
        repeat (40) @(posedge clk);

        for (int t = 0; t < 150; t++) begin
            r = $urandom_range(0, 19);
            if (r < 2) bus_xfer(1'($urandom_range(0, 1)), 1, 8'($urandom));
            else if (r < 10) bus_xfer(1, 0, 8'($urandom));
            else begin
                case (r)
                    10: d = 8'h80 | 8'($urandom_range(0, 15));
                    11: d = 8'hC0 | 8'($urandom_range(0, 15));
                    12: d = 8'($urandom_range(4, 7));
                    13: d = 8'($urandom_range(16, 31));
                    14: d = 8'($urandom_range(32, 63));
                    15: d = 8'($urandom_range(64, 127));
                    16: d = 8'($urandom_range(8, 15));
                    17: d = 8'($urandom_range(0, 3));
                    default: d = 8'($urandom);
                endcase
                bus_xfer(0, 0, d);
            end
        end
        repeat (40) @(posedge clk);

        // Reset in the middle of a clear.
        bus_xfer(0, 0, 8'h0C);
        bus_xfer(0, 0, 8'h85);
        bus_xfer(1, 0, 8'h7E);
        chk_en = 0;
        strobe_raw(0, 8'h01);
        repeat (10) @(posedge clk);
        #2;
        chk("midclr_busy", busy, 1);
        rst = 1'b0;
        #1;
        chk("midclr_busy_rst", busy, 0);
        chk("midclr_overrun", overrun, 0);
        chk("midclr_addr", ddram_addr, 0);
        chk("midclr_disp", disp_on, 0);
        chk("midclr_rd_char", rd_char, 8'h20);
        chk("midclr_pulses", {cmd_pulse, data_pulse}, 0);
        m_reset();
        @(posedge clk); #1 rst = 1'b1;
        chk_en = 1;
        repeat (40) @(posedge clk);

        $display("[TB] %0d tests run, %0d failed", tests, errs);
        $finish;
    end
endmodule
